color_lut_arb: RTL and testbench
================================

# color_lut_arb

Two-requester arbiter that shares the single combinational 8-entry block colour LUT (3-bit block type to 12-bit RGB444) between the playfield renderer (requester 0) and the next-piece preview renderer (requester 1). The arbiter grants at most one lookup per cycle, drives the LUT type input, and registers the returned colour into a per-requester response slot with fixed 1-cycle latency. It also keeps a saturating contention counter for debug readout. It sits between both renderers and the external colour LUT instance, ahead of the VGA pixel mux.

## Interface
Parameters:
- TYPE_W, 3, block type width (LUT address)
- COLOR_W, 12, colour width ({R,G,B} × 4 bits)
- CNT_W, 8, contention counter width

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 lookup request
- req0_type  in  TYPE_W  requester 0 block type
- req0_ready  out  1  requester 0 granted this cycle (combinational)
- req1_valid  in  1  requester 1 lookup request
- req1_type  in  TYPE_W  requester 1 block type
- req1_ready  out  1  requester 1 granted this cycle (combinational)
- lut_type  out  TYPE_W  type driven to the colour LUT
- lut_color  in  COLOR_W  colour returned by the LUT (combinational from lut_type)
- rsp0_valid  out  1  response for requester 0, 1-cycle pulse
- rsp0_color  out  COLOR_W  registered colour for requester 0
- rsp1_valid  out  1  response for requester 1, 1-cycle pulse
- rsp1_color  out  COLOR_W  registered colour for requester 1
- contend_cnt  out  CNT_W  saturating count of cycles with both requests valid

## Operation
- A request transfers when reqN_valid && reqN_ready. reqN_ready depends only on both valids and the arbitration state, never on lut_color.
- Only one valid: that requester is granted.
- Both valid, round-robin: the requester not granted most recently wins. last_grant updates only on a transfer.
- No valid: no grant, lut_type = 0, no LUT result captured.
- lut_type = granted requester's type. The LUT output is captured at the same edge into rspN_color of the granted requester. rspN_valid = 1 for exactly the following cycle.
- The non-granted response slot holds its previous colour, and its rspN_valid is 0.
- A requester holding valid while not ready must keep its type stable. The arbiter does not check this.
- Responses have no backpressure. Consumers must accept rspN in its valid cycle.
- contend_cnt increments by 1 on each cycle with req0_valid && req1_valid, and saturates at 2^CNT_W−1 (255 default) with no wrap.

## Timing
- Reset values (rst_n low at a clock edge): rsp0_valid = rsp1_valid = 0, rsp0_color = rsp1_color = 0, contend_cnt = 0, last_grant = 1 (requester 0 wins the first conflict).
- During reset cycles req0_ready and req1_ready are forced to 0 and lut_type to 0.
- Latency: request accepted at edge N, so rspN_valid and rspN_color are visible after edge N.
- Throughput: 1 lookup per cycle total. Under continuous contention grants alternate 0,1,0,1…
- Reset asserted mid-stream: an in-flight response is dropped (rsp valid cleared at that edge) and arbitration restarts from the reset state.

## Configuration
- COLOR_ARB_FIXED_PRIO_EN defined: requester 0 always wins on conflict. last_grant is unused and tied off. Requester 1 is served only in cycles when req0_valid = 0.
- COLOR_ARB_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.
- All other behaviour, including latency, reset values and the counter, is identical in both builds.

## Test plan
- Reset, then req0_valid = 1 with type 3'b001 for one cycle, LUT model attached. Required: req0_ready = 1, lut_type = 1, next cycle rsp0_valid = 1 and rsp0_color = 12'h0FF, rsp1_valid = 0.
- Both requesters valid for 4 cycles, types 3'b010 and 3'b101, after reset. Required: grants alternate 0,1,0,1; rsp colours alternate 12'hFF0 (rsp0) and 12'hF00 (rsp1); contend_cnt = 4.
- Same stimulus with COLOR_ARB_FIXED_PRIO_EN. Required: req0 granted all 4 cycles, req1_ready = 0 throughout, rsp1_valid never asserts.
- Both requesters valid for 300 cycles. Required: contend_cnt reaches 255 and stays at 255.
- Single requester 1 valid with type 3'b111, rst_n driven low on the grant-next edge. Required: rsp1_valid = 0 and rsp1_color = 0 after that edge; first conflict after release is granted to requester 0.
- No requests for 10 cycles. Required: lut_type = 0, both ready = 0, both rsp_valid = 0, response colours unchanged from their previous values.

Source files
------------

// File: rtl/color_lut_arb_if.sv
// Request/response/LUT bundle for color_lut_arb. The slave side is the arbiter.
// The master side is the two renderers plus the external colour LUT.
interface color_lut_arb_if #(
   parameter int unsigned TYPE_W  = 3,
   parameter int unsigned COLOR_W = 12
);
   logic               req0_valid;
   logic [TYPE_W-1:0]  req0_type;
   logic               req0_ready;
   logic               req1_valid;
   logic [TYPE_W-1:0]  req1_type;
   logic               req1_ready;
   logic [TYPE_W-1:0]  lut_type;
   logic [COLOR_W-1:0] lut_color;
   logic               rsp0_valid;
   logic [COLOR_W-1:0] rsp0_color;
   logic               rsp1_valid;
   logic [COLOR_W-1:0] rsp1_color;

   modport slave (
      input  req0_valid, req0_type, req1_valid, req1_type, lut_color,
      output req0_ready, req1_ready, lut_type,
      output rsp0_valid, rsp0_color, rsp1_valid, rsp1_color
   );

   modport master (
      output req0_valid, req0_type, req1_valid, req1_type, lut_color,
      input  req0_ready, req1_ready, lut_type,
      input  rsp0_valid, rsp0_color, rsp1_valid, rsp1_color
   );
endinterface

// File: rtl/color_lut_arb.sv
// Two-requester arbiter sharing one combinational colour LUT, with 1-cycle registered responses.
// Define COLOR_ARB_FIXED_PRIO_EN for fixed priority to requester 0; otherwise round-robin.
module color_lut_arb #(
   parameter int unsigned TYPE_W  = 3,
   parameter int unsigned COLOR_W = 12,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   color_lut_arb_if.slave   bus,
   output logic [CNT_W-1:0] contend_cnt
);

   logic gnt0;
   logic gnt1;
   logic both;

   assign both = bus.req0_valid && bus.req1_valid;

`ifdef COLOR_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         gnt0 = bus.req0_valid;
         gnt1 = bus.req1_valid && !bus.req0_valid;
      end
   end
`else
   typedef enum logic {LAST_REQ0, LAST_REQ1} last_t;

   last_t last_q;
   last_t last_d;

   // Reset to LAST_REQ1 so requester 0 wins the first conflict.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= LAST_REQ1;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      last_d = last_q;
      if (rst_n) begin
         if (both) begin
            gnt0 = (last_q == LAST_REQ1);
            gnt1 = (last_q == LAST_REQ0);
         end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
         end
         if (gnt0) begin
            last_d = LAST_REQ0;
         end else if (gnt1) begin
            last_d = LAST_REQ1;
         end
      end
   end
`endif

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   always_comb begin
      bus.lut_type = '0;
      if (gnt0) begin
         bus.lut_type = bus.req0_type;
      end else if (gnt1) begin
         bus.lut_type = bus.req1_type;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp0_color <= '0;
         bus.rsp1_color <= '0;
         contend_cnt    <= '0;
      end else begin
         bus.rsp0_valid <= gnt0;
         bus.rsp1_valid <= gnt1;
         if (gnt0) begin
            bus.rsp0_color <= bus.lut_color;
         end
         if (gnt1) begin
            bus.rsp1_color <= bus.lut_color;
         end
         if (both && (contend_cnt != '1)) begin
            contend_cnt <= contend_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_color_lut_arb.sv
// Directed bench for color_lut_arb with a behavioural block-colour LUT attached.
module tb_color_lut_arb;

`ifdef COLOR_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] contend_cnt;
   int         n_cmp = 0;
   int         n_err = 0;

   color_lut_arb_if #(.TYPE_W(3), .COLOR_W(12)) bus ();

   color_lut_arb #(.TYPE_W(3), .COLOR_W(12), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .contend_cnt (contend_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] lut_rom(input logic [2:0] t);
      case (t)
         3'd0: lut_rom = 12'h000;
         3'd1: lut_rom = 12'h0FF;
         3'd2: lut_rom = 12'hFF0;
         3'd3: lut_rom = 12'hF0F;
         3'd4: lut_rom = 12'h0F0;
         3'd5: lut_rom = 12'hF00;
         3'd6: lut_rom = 12'h00F;
         default: lut_rom = 12'hF80;
      endcase
   endfunction

   assign bus.lut_color = lut_rom(bus.lut_type);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs after the falling edge, then let combinational outputs settle.
   task automatic drive(input logic r, input logic v0, input logic [2:0] t0,
                        input logic v1, input logic [2:0] t1);
      @(negedge clk);
      rst_n          = r;
      bus.req0_valid = v0;
      bus.req0_type  = t0;
      bus.req1_valid = v1;
      bus.req1_type  = t1;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        eg0;
      logic [11:0] e0col;
      logic [11:0] e1col;

      bus.req0_valid = 1'b0;
      bus.req0_type  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_type  = '0;

      // Reset with requests present: grants and LUT address must be forced low.
      drive(1'b0, 1'b1, 3'd4, 1'b1, 3'd6);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_lut_type", bus.lut_type, 0);
      tick;
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      tick;
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_rsp0_color", bus.rsp0_color, 0);
      chk("rst_rsp1_color", bus.rsp1_color, 0);
      chk("rst_cnt", contend_cnt, 0);

      // Single lookup from requester 0.
      drive(1'b1, 1'b1, 3'd1, 1'b0, 3'd0);
      chk("single_ready0", bus.req0_ready, 1);
      chk("single_ready1", bus.req1_ready, 0);
      chk("single_lut_type", bus.lut_type, 1);
      tick;
      chk("single_rsp0_valid", bus.rsp0_valid, 1);
      chk("single_rsp0_color", bus.rsp0_color, 12'h0FF);
      chk("single_rsp1_valid", bus.rsp1_valid, 0);
      chk("single_cnt", contend_cnt, 0);

      // Four cycles of contention after a fresh reset.
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      tick;
      e0col = 12'h000;
      e1col = 12'h000;
      for (int k = 0; k < 4; k++) begin
         eg0 = FIXED || (k % 2 == 0);
         drive(1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
         chk("cont_ready0", bus.req0_ready, eg0);
         chk("cont_ready1", bus.req1_ready, !eg0);
         chk("cont_lut_type", bus.lut_type, eg0 ? 3'd2 : 3'd5);
         tick;
         if (eg0) e0col = 12'hFF0;
         else     e1col = 12'hF00;
         chk("cont_rsp0_valid", bus.rsp0_valid, eg0);
         chk("cont_rsp1_valid", bus.rsp1_valid, !eg0);
         chk("cont_rsp0_color", bus.rsp0_color, e0col);
         chk("cont_rsp1_color", bus.rsp1_color, e1col);
         chk("cont_cnt", contend_cnt, k + 1);
      end

      // Long contention: counter saturates at 255 without wrapping.
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      tick;
      for (int k = 1; k <= 300; k++) begin
         drive(1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
         tick;
         if (k == 254 || k == 255 || k == 256 || k == 300)
            chk("sat_cnt", contend_cnt, (k > 255) ? 255 : k);
      end

      // Mid-stream reset drops the in-flight response and restarts arbitration.
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      tick;
      drive(1'b1, 1'b0, 3'd0, 1'b1, 3'd7);
      chk("mid_ready1", bus.req1_ready, 1);
      tick;
      chk("mid_rsp1_valid_a", bus.rsp1_valid, 1);
      chk("mid_rsp1_color_a", bus.rsp1_color, 12'hF80);
      drive(1'b1, 1'b1, 3'd1, 1'b0, 3'd0);
      tick;
      chk("mid_rsp0_color_b", bus.rsp0_color, 12'h0FF);
      chk("mid_rsp1_color_b", bus.rsp1_color, 12'hF80);
      chk("mid_rsp1_valid_b", bus.rsp1_valid, 0);
      drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd7);
      chk("mid_rst_ready1", bus.req1_ready, 0);
      chk("mid_rst_lut_type", bus.lut_type, 0);
      tick;
      chk("mid_rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("mid_rst_rsp1_color", bus.rsp1_color, 0);
      chk("mid_rst_rsp0_color", bus.rsp0_color, 0);
      drive(1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
      chk("post_rst_ready0", bus.req0_ready, 1);
      chk("post_rst_ready1", bus.req1_ready, 0);
      tick;
      chk("post_rst_rsp0_valid", bus.rsp0_valid, 1);
      chk("post_rst_rsp0_color", bus.rsp0_color, 12'hFF0);

      // Idle: no grants, LUT address parked at 0, response colours held.
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'b0, 3'd3, 1'b0, 3'd6);
         chk("idle_lut_type", bus.lut_type, 0);
         chk("idle_ready0", bus.req0_ready, 0);
         chk("idle_ready1", bus.req1_ready, 0);
         tick;
         chk("idle_rsp0_valid", bus.rsp0_valid, 0);
         chk("idle_rsp1_valid", bus.rsp1_valid, 0);
         chk("idle_rsp0_color", bus.rsp0_color, 12'hFF0);
         chk("idle_rsp1_color", bus.rsp1_color, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
